// File: rtl/arb_txn_mux.sv
// Arbitrated transaction mux: one user at a time wins the arbiter, its command is
// issued to a single memory port, and the completion (or a timeout) is returned.
module arb_txn_mux #(
  parameter int USER   = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [USER-1:0]   u_valid,
  input  logic [USER-1:0]   u_we,
  input  logic [USER*AW-1:0] u_addr,
  input  logic [USER*DW-1:0] u_wdata,
  output logic [USER-1:0]   u_ready,
  output logic [USER-1:0]   u_rvalid,
  output logic [DW-1:0]     u_rdata,
  output logic [USER-1:0]   arb_request,
  input  logic [USER-1:0]   arb_grant,
  output logic              m_valid,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DW-1:0]     m_rdata,
  output logic              grant_err,
  output logic              timeout
);

  localparam int USER_LOG2 = (USER > 1) ? $clog2(USER) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t               state_q, state_d;
  logic [USER_LOG2-1:0] owner_q, grant_idx;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic [7:0]           cnt_q, cnt_d;
  logic [USER-1:0]      rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic                 gerr_q, to_q;
  logic                 grant_onehot, legal, illegal, done, done_to;

  function automatic logic [DW-1:0] timeout_fill();
    return {(DW/32){32'hDEADBEEF}};
  endfunction

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < USER; i++)
      if (arb_grant[i]) grant_idx = USER_LOG2'(i);
  end

  assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - USER'(1))) == '0);
  assign legal   = (state_q == IDLE) && grant_onehot && ((arb_grant & u_valid) != '0);
  assign illegal = (state_q == IDLE) && (u_valid != '0) && !legal;

  assign arb_request = (state_q == IDLE) ? u_valid : '0;
  assign u_ready     = legal ? arb_grant : '0;
  assign m_valid     = (state_q == ISSUE);
  assign m_we        = we_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign u_rvalid    = rvalid_q;
  assign u_rdata     = rdata_q;
  assign grant_err   = gerr_q;
  assign timeout     = to_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    done_to = 1'b0;
    case (state_q)
      IDLE: if (legal) state_d = ISSUE;
      ISSUE: begin
        if (m_ready) begin
          if (m_rvalid) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        // A response arriving on the expiry cycle beats the timeout.
        if (m_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if ((cnt_q + 8'd1) == 8'(TO_CYC)) begin
          done    = 1'b1;
          done_to = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      gerr_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (legal) begin
        owner_q <= grant_idx;
        we_q    <= u_we[grant_idx];
        addr_q  <= u_addr[AW*grant_idx +: AW];
        wdata_q <= u_wdata[DW*grant_idx +: DW];
      end
      rvalid_q <= done ? (USER'(1) << owner_q) : '0;
      if (done) rdata_q <= done_to ? timeout_fill() : m_rdata;
      gerr_q <= illegal;
      to_q   <= done_to;
    end
  end

endmodule

// File: tb/tb_arb_txn_mux.sv
// Randomized bench for arb_txn_mux: round-robin arbiter and memory models drive the
// block, expected completions go to a queue that a posedge monitor drains.
module tb_arb_txn_mux;
  localparam int USER = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 8;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic [USER-1:0]   u_valid = '0, u_we = '0;
  logic [USER*AW-1:0] u_addr = '0;
  logic [USER*DW-1:0] u_wdata = '0;
  logic [USER-1:0]   u_ready, u_rvalid, arb_request, arb_grant;
  logic [DW-1:0]     u_rdata, m_wdata;
  logic [AW-1:0]     m_addr;
  logic              m_valid, m_we, grant_err, timeout;
  logic              m_ready = 1'b0, m_rvalid = 1'b0;
  logic [DW-1:0]     m_rdata = '0;

  always #5 CLK = ~CLK;

  arb_txn_mux #(.USER(USER), .AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .u_valid(u_valid), .u_we(u_we), .u_addr(u_addr),
    .u_wdata(u_wdata), .u_ready(u_ready), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
    .arb_request(arb_request), .arb_grant(arb_grant), .m_valid(m_valid), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .grant_err(grant_err), .timeout(timeout)
  );

  typedef struct {
    int            user;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_rdata = '0;
  int            rr_last = USER - 1;
  logic          ovr_en = 1'b0;
  logic [USER-1:0] ovr_val = '0;

  function automatic int rr_pick(input logic [USER-1:0] req, input int last);
    for (int k = 1; k <= USER; k++) begin
      int c;
      c = (last + k) % USER;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  // Round-robin arbiter, with an override used to inject illegal grants.
  always_comb begin
    arb_grant = '0;
    if (ovr_en) arb_grant = ovr_val;
    else if (arb_request != '0) arb_grant = USER'(1) << rr_pick(arb_request, rr_last);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  exp_t e;
  always @(posedge CLK) begin
    #1;
    if (RSTN) begin
      if (u_rvalid != '0 || timeout) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_completion actual u_rvalid=%b timeout=%b required=none", u_rvalid, timeout);
        end else begin
          e = q.pop_front();
          check("u_rvalid", 64'(u_rvalid), 64'(1) << e.user);
          check("u_rdata", 64'(u_rdata), 64'(e.data));
          check("timeout", 64'(timeout), 64'(e.to));
          last_rdata = e.data;
        end
      end else begin
        check("u_rdata_hold", 64'(u_rdata), 64'(last_rdata));
      end
    end else begin
      last_rdata = '0;
    end
  end

  task automatic randomize_users();
    for (int i = 0; i < USER; i++) begin
      u_addr[AW*i +: AW]  = $urandom;
      u_wdata[DW*i +: DW] = $urandom;
      u_we[i]             = 1'($urandom % 2);
    end
  endtask

  // mode 0: response with m_ready, 1: response after d wait cycles,
  // 2: no response (timeout), 3: reset during the wait.
  task automatic do_txn(input logic [USER-1:0] mask, input int nr, input int mode,
                        input int d, output int gu);
    int g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic ewe;
    randomize_users();
    u_valid  = mask;
    m_ready  = 1'b0;
    m_rvalid = 1'($urandom % 2);
    m_rdata  = $urandom;
    g  = rr_pick(mask, rr_last);
    gu = g;
    ea  = u_addr[AW*g +: AW];
    ewd = u_wdata[DW*g +: DW];
    ewe = u_we[g];
    #1;
    check("arb_request_idle", 64'(arb_request), 64'(mask));
    check("u_ready", 64'(u_ready), 64'(1) << g);
    check("m_valid_idle", 64'(m_valid), 64'd0);
    @(negedge CLK);
    rr_last = g;
    for (int k = 0; k <= nr; k++) begin
      if (k > 0) @(negedge CLK);
      randomize_users();
      m_rdata = $urandom;
      if (k < nr) begin
        m_ready  = 1'b0;
        m_rvalid = 1'($urandom % 2);
      end else begin
        m_ready  = 1'b1;
        m_rvalid = (mode == 0);
        if (mode == 0) q.push_back('{g, m_rdata, 1'b0});
      end
      #1;
      check("m_valid_issue", 64'(m_valid), 64'd1);
      check("m_addr", 64'(m_addr), 64'(ea));
      check("m_wdata", 64'(m_wdata), 64'(ewd));
      check("m_we", 64'(m_we), 64'(ewe));
      check("arb_request_busy", 64'(arb_request), 64'd0);
      check("u_ready_busy", 64'(u_ready), 64'd0);
    end
    if (mode == 1 || mode == 2) begin
      for (int c = 1; c <= ((mode == 1) ? d : TO); c++) begin
        @(negedge CLK);
        m_ready  = 1'b0;
        m_rdata  = $urandom;
        m_rvalid = (mode == 1) && (c == d);
        if (mode == 1 && c == d) q.push_back('{g, m_rdata, 1'b0});
        if (mode == 2 && c == TO) q.push_back('{g, {(DW/32){32'hDEADBEEF}}, 1'b1});
        #1;
        check("m_valid_wait", 64'(m_valid), 64'd0);
        check("arb_request_wait", 64'(arb_request), 64'd0);
      end
    end
    if (mode == 3) begin
      for (int c = 1; c <= 3; c++) begin
        @(negedge CLK);
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
      end
      #2;
      u_valid = '0;
      RSTN    = 1'b0;
      #1;
      check("rst_u_rvalid", 64'(u_rvalid), 64'd0);
      check("rst_u_rdata", 64'(u_rdata), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_we", 64'(m_we), 64'd0);
      check("rst_m_addr", 64'(m_addr), 64'd0);
      check("rst_m_wdata", 64'(m_wdata), 64'd0);
      check("rst_grant_err", 64'(grant_err), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      for (int c = 0; c < TO + 4; c++) begin
        @(negedge CLK);
        m_rvalid = 1'($urandom % 2);
        #1;
        check("post_rst_m_valid", 64'(m_valid), 64'd0);
      end
      m_rvalid = 1'b0;
    end
    @(negedge CLK);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL completion_missing actual pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic bad_grant(input int kind);
    u_valid  = 4'b0110;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    ovr_en   = 1'b1;
    case (kind)
      0:       ovr_val = 4'b0000;
      1:       ovr_val = 4'b0110;
      default: ovr_val = 4'b1000;
    endcase
    #1;
    check("bad_u_ready", 64'(u_ready), 64'd0);
    @(negedge CLK);
    ovr_en  = 1'b0;
    u_valid = '0;
    #1;
    check("grant_err_pulse", 64'(grant_err), 64'd1);
    check("bad_stay_idle", 64'(m_valid), 64'd0);
    @(negedge CLK);
    #1;
    check("grant_err_clear", 64'(grant_err), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gu;
    logic [USER-1:0] seen;
    logic [USER-1:0] mask;
    int mode;
    repeat (3) @(negedge CLK);
    #1;
    check("reset_u_rvalid", 64'(u_rvalid), 64'd0);
    check("reset_u_rdata", 64'(u_rdata), 64'd0);
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_addr", 64'(m_addr), 64'd0);
    check("reset_grant_err", 64'(grant_err), 64'd0);
    check("reset_timeout", 64'(timeout), 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    do_txn(4'b0010, 0, 1, 1, gu);
    seen = '0;
    for (int i = 0; i < USER; i++) begin
      do_txn(4'b1111, 0, 0, 0, gu);
      seen[gu] = 1'b1;
    end
    check("all_users_served", 64'(seen), 64'hF);
    for (int k = 0; k < 3; k++) bad_grant(k);
    do_txn(4'b0100, 1, 2, 0, gu);
    do_txn(4'b1001, 0, 1, TO, gu);
    do_txn(4'b0001, 2, 3, 0, gu);
    do_txn(4'b1000, 0, 0, 0, gu);
    for (int n = 0; n < 60; n++) begin
      mask = USER'($urandom_range(1, 15));
      mode = $urandom_range(0, 9);
      mode = (mode < 4) ? 0 : (mode < 8) ? 1 : 2;
      do_txn(mask, $urandom_range(0, 3), mode, $urandom_range(1, TO), gu);
      if ($urandom_range(0, 7) == 0) bad_grant($urandom_range(0, 2));
    end
    u_valid = '0;
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
